// File: rtl/peripheral_seq_pkg.sv
// Shared types and widths for the peripheral operand sequencer.
package peripheral_seq_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, SEND} seq_state_t;

    localparam int unsigned DEF_NBYTES    = 8;
    localparam int unsigned DEF_RES_BYTES = 4;
    localparam int unsigned IDX_W         = 4;
    localparam int unsigned BYTE_W        = 8;
    localparam int unsigned RES_W         = 32;

endpackage

// File: rtl/peripheral_result_serializer.sv
// Captures the ALU result and streams it out LSB-first over a valid/ready byte port.
module peripheral_result_serializer
    import peripheral_seq_pkg::*;
#(
    parameter int unsigned RES_BYTES = DEF_RES_BYTES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [RES_W-1:0]  result,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              last_accept
);

    localparam int unsigned K_W = (RES_BYTES > 1) ? $clog2(RES_BYTES) : 1;

    logic [RES_W-1:0] res_q;
    logic [K_W-1:0]   k_q;
    logic             tx_accept_c;

    assign tx_accept_c = tx_valid & tx_ready;
    assign last_accept = tx_accept_c & (k_q == K_W'(RES_BYTES - 1));

    // tx_data is loaded ahead of each handshake so it stays stable while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q    <= '0;
            k_q      <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (load) begin
            res_q    <= result;
            k_q      <= '0;
            tx_valid <= 1'b1;
            tx_data  <= result[BYTE_W-1:0];
        end else if (last_accept) begin
            tx_valid <= 1'b0;
            k_q      <= '0;
        end else if (tx_accept_c) begin
            k_q     <= k_q + K_W'(1);
            tx_data <= BYTE_W'(res_q >> (BYTE_W * (int'(k_q) + 1)));
        end
    end

endmodule

// File: rtl/peripheral_operand_sequencer.sv
// Operand-load / compute / result-return sequencer: byte stream in, operand
// register writes, ALU handshake, result bytes out.
module peripheral_operand_sequencer
    import peripheral_seq_pkg::*;
#(
    parameter int unsigned NBYTES         = DEF_NBYTES,
    parameter int unsigned RES_BYTES      = DEF_RES_BYTES,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [BYTE_W-1:0] inputdata,
    output logic              loaddata,
    output logic [IDX_W-1:0]  datainput_i,
    output logic              alu_start,
    input  logic              alu_done,
    input  logic [RES_W-1:0]  result_in,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_t       state, state_next;
    logic [IDX_W-1:0] idx, idx_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             load_c;
    logic             capture_c;
    logic             timeout_c;
    logic             last_accept;

    // Next-state, byte index and idle-timeout logic
    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        load_c     = 1'b0;
        capture_c  = 1'b0;
        timeout_c  = 1'b0;
        unique case (state)
            IDLE, LOAD: begin
                if (rx_valid && rx_ready) begin
                    load_c   = 1'b1;
                    cnt_next = '0;
                    if (idx == IDX_W'(NBYTES - 1)) begin
                        idx_next   = '0;
                        state_next = START;
                    end else begin
                        idx_next   = idx + IDX_W'(1);
                        state_next = LOAD;
                    end
                end else if (state == LOAD) begin
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_c  = 1'b1;
                        idx_next   = '0;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else if (cnt != '1) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            START: state_next = WAIT;
            WAIT: begin
                if (alu_done) begin
                    capture_c  = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (last_accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs; rx_ready/busy follow the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            rx_ready    <= 1'b0;
            busy        <= 1'b0;
            alu_start   <= 1'b0;
            err_timeout <= 1'b0;
            loaddata    <= 1'b0;
            inputdata   <= '0;
            datainput_i <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            cnt         <= cnt_next;
            rx_ready    <= (state_next == IDLE) || (state_next == LOAD);
            busy        <= (state_next != IDLE);
            alu_start   <= (state == START);
            err_timeout <= timeout_c;
            loaddata    <= load_c;
            if (load_c) begin
                inputdata   <= rx_data;
                datainput_i <= idx;
            end
        end
    end

    peripheral_result_serializer #(
        .RES_BYTES(RES_BYTES)
    ) u_serializer (
        .clk        (clk),
        .reset      (reset),
        .load       (capture_c),
        .result     (result_in),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .last_accept(last_accept)
    );

endmodule
